// File: rtl/div_pkg.sv
// Shared types and constants for the radix-2 restoring divide sequencer.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DIV_W     = 32;
    localparam int DIV_ITERS = 32;
    localparam int DIV_RES_W = 64;
    localparam int CNT_W     = $clog2(DIV_ITERS) + 1;

    // Two's-complement negate when en is set; used for |x| on entry and sign fix-up on exit.
    function automatic logic [DIV_W-1:0] neg_if(input logic [DIV_W-1:0] v, input logic en);
        logic [DIV_W-1:0] r;
        if (en) begin
            r = {DIV_W{1'b0}} - v;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-divide step: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference when it does not borrow.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dvd_msb_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0]   shifted_s;
    logic [WIDTH+1:0] diff_s;
    logic             borrow_s;

    // The shifted remainder can be WIDTH+1 bits wide; the extra top bit catches the borrow.
    always_comb begin
        shifted_s = {rem_i, dvd_msb_i};
        diff_s    = {1'b0, shifted_s} - {2'b00, dvs_i};
        borrow_s  = diff_s[WIDTH+1];
        q_bit_o   = ~borrow_s;
        if (borrow_s) begin
            rem_o = shifted_s[WIDTH-1:0];
        end else begin
            rem_o = diff_s[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer: 32 restoring steps, result as {remainder, quotient}.
// Define DIV_ZERO_FAST_EN to finish a divide-by-zero in one cycle with {a, all-ones}.
module div_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 annul,
    input  logic                 pipe_stall,
    output logic                 stall,
    output logic                 result_ready,
    output logic [DIV_RES_W-1:0] div_res
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_ITERS - 1);

    div_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [DIV_RES_W-1:0] res_q, res_d;

    logic [WIDTH-1:0]     step_rem_s;
    logic                 step_q_s;
    logic [WIDTH-1:0]     quo_next_s;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .dvd_msb_i (quo_q[WIDTH-1]),
        .dvs_i     (dvs_q),
        .rem_o     (step_rem_s),
        .q_bit_o   (step_q_s)
    );

    // The dividend register doubles as the quotient: each step shifts a dividend bit out and a quotient bit in.
    always_comb begin
        quo_next_s = {quo_q[WIDTH-2:0], step_q_s};
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        res_d      = res_q;
        if (annul) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dvs_d     = neg_if(b, signed_div & b[WIDTH-1]);
                        quo_d     = neg_if(a, signed_div & a[WIDTH-1]);
                        rem_d     = {WIDTH{1'b0}};
                        cnt_d     = {CNT_W{1'b0}};
                        neg_quo_d = signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem_d = signed_div & a[WIDTH-1];
                        state_d   = BUSY;
`ifdef DIV_ZERO_FAST_EN
                        if (b == {WIDTH{1'b0}}) begin
                            state_d = DONE;
                            res_d   = {a, {WIDTH{1'b1}}};
                        end else begin
                            state_d = BUSY;
                        end
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
                BUSY: begin
                    rem_d = step_rem_s;
                    quo_d = quo_next_s;
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == LAST_STEP) begin
                        state_d = DONE;
                        res_d   = {neg_if(step_rem_s, neg_rem_q), neg_if(quo_next_s, neg_quo_q)};
                    end else begin
                        state_d = BUSY;
                    end
                end
                DONE: begin
                    if (pipe_stall) begin
                        state_d = DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Sequencer state, datapath and held result.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            rem_q     <= {WIDTH{1'b0}};
            quo_q     <= {WIDTH{1'b0}};
            dvs_q     <= {WIDTH{1'b0}};
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            res_q     <= {DIV_RES_W{1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            res_q     <= res_d;
        end
    end

    // Stall must drop in DONE and during a flush so the pipeline can move on the same cycle.
    always_comb begin
        stall        = ~annul & (((state_q == IDLE) & start) | (state_q == BUSY));
        result_ready = ~annul & (state_q == DONE);
        div_res      = res_q;
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: stimulus queues expected results, a monitor checks them.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        annul = 1'b0;
    logic        pipe_stall = 1'b0;
    logic        stall;
    logic        result_ready;
    logic [63:0] div_res;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
    localparam logic [63:0] NEG7_DIV0 = 64'hFFFF_FFF9_FFFF_FFFF;
`else
    localparam int ZLAT = 33;
    localparam logic [63:0] NEG7_DIV0 = 64'hFFFF_FFF9_0000_0001;
`endif

    typedef struct {
        logic [63:0] res;
        int          cyc;
        int          hold;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          hold_left = 0;
    logic [63:0] cur_res = 64'd0;

    div_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .signed_div   (signed_div),
        .a            (a),
        .b            (b),
        .annul        (annul),
        .pipe_stall   (pipe_stall),
        .stall        (stall),
        .result_ready (result_ready),
        .div_res      (div_res)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops an expectation on the first result_ready cycle, then checks the hold.
    always @(negedge clk) begin
        if (resetn) begin
            if (result_ready) begin
                if (hold_left > 0) begin
                    chk("res_hold", div_res, cur_res);
                    hold_left--;
                end else if (sb.size() == 0) begin
                    chk("unexpected_ready", 64'(result_ready), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    cur_res   = e.res;
                    hold_left = e.hold;
                    chk("div_res", div_res, e.res);
                    chk("latency", 64'(cyc), 64'(e.cyc));
                end
            end else if (hold_left > 0) begin
                chk("ready_dropped", 64'(result_ready), 64'd1);
                hold_left = 0;
            end
        end
    end

    task automatic run_div(input logic sd, input logic [31:0] av, input logic [31:0] bv,
                           input logic [63:0] exp, input int lat, input int ps);
        int c0;
        @(posedge clk);
        #1;
        start = 1'b1;
        signed_div = sd;
        a = av;
        b = bv;
        c0 = cyc;
        sb.push_back('{exp, c0 + lat, ps});
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            chk("stall_busy", 64'(stall), 64'd1);
        end
        @(posedge clk);
        #1;
        pipe_stall = (ps > 0);
        for (int j = 0; j <= ps; j++) begin
            @(negedge clk);
            chk("stall_done", 64'(stall), 64'd0);
            @(posedge clk);
            #1;
            if (j == ps - 1) pipe_stall = 1'b0;
        end
        start = 1'b0;
        @(negedge clk);
        chk("idle_stall", 64'(stall), 64'd0);
        chk("idle_ready", 64'(result_ready), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 resetn = 1'b0;
        #1;
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_ready", 64'(result_ready), 64'd0);
        chk("rst_res", div_res, 64'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        run_div(1'b0, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 33, 0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, 0);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 33, 0);
        run_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 64'hFFFF_FFFE_0000_000E, 33, 0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33, 0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 64'h0000_0000_FFFF_FFFF, 33, 0);
        run_div(1'b0, 32'd7, 32'd100, 64'h0000_0007_0000_0000, 33, 0);
        run_div(1'b0, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, ZLAT, 0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd0, NEG7_DIV0, ZLAT, 0);

        // Flush in BUSY cycle 10, then a clean retry.
        @(posedge clk);
        #1;
        start = 1'b1;
        signed_div = 1'b0;
        a = 32'd100;
        b = 32'd7;
        repeat (10) @(posedge clk);
        #1 annul = 1'b1;
        @(negedge clk);
        chk("annul_stall", 64'(stall), 64'd0);
        chk("annul_ready", 64'(result_ready), 64'd0);
        @(posedge clk);
        #1;
        annul = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("annul_idle", 64'(stall), 64'd0);
        run_div(1'b0, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 33, 0);

        // Back-pressure holds the result for three extra cycles while start stays high.
        run_div(1'b0, 32'd1000, 32'd3, 64'h0000_0001_0000_014D, 33, 3);

        // Reset in BUSY cycle 20 clears everything at once.
        @(posedge clk);
        #1;
        start = 1'b1;
        a = 32'd100;
        b = 32'd7;
        repeat (20) @(posedge clk);
        #1;
        resetn = 1'b0;
        start = 1'b0;
        #1;
        chk("midrst_stall", 64'(stall), 64'd0);
        chk("midrst_ready", 64'(result_ready), 64'd0);
        chk("midrst_res", div_res, 64'd0);
        @(posedge clk);
        #1 resetn = 1'b1;
        run_div(1'b0, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 33, 0);

        repeat (5) @(posedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
